// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate byte cache in front of a 32-bit block memory.
// Optional hit/miss counters are compiled in with DCACHE_STATS_EN.
module data_cache #(
  parameter int INDEX_BITS = 3
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        READ,
  input  logic        WRITE,
  input  logic [7:0]  ADDRESS,
  input  logic [7:0]  WRITEDATA,
  output logic [7:0]  READDATA,
  output logic        BUSYWAIT,
  output logic        MEM_READ,
  output logic        MEM_WRITE,
  output logic [5:0]  MEM_ADDRESS,
  output logic [31:0] MEM_WRITEDATA,
  input  logic [31:0] MEM_READDATA,
  input  logic        MEM_BUSYWAIT,
  output logic [1:0]  o_dbg_state
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0] HIT_COUNT,
  output logic [15:0] MISS_COUNT
`endif
);

  localparam int TAG_BITS = 6 - INDEX_BITS;
  localparam int SETS     = 1 << INDEX_BITS;

  typedef enum logic [1:0] {S_IDLE, S_WRITEBACK, S_FETCH, S_UPDATE} state_t;

  // Handshake: the CPU holds READ/WRITE and ADDRESS until it samples BUSYWAIT=0;
  // memory requests are held until a rising edge sees MEM_BUSYWAIT=0.
  state_t                r_state;
  state_t                w_next;
  logic [SETS-1:0]       r_valid;
  logic [SETS-1:0]       r_dirty;
  logic [TAG_BITS-1:0]   r_tag  [SETS];
  logic [31:0]           r_data [SETS];
  logic [TAG_BITS-1:0]   r_miss_tag;
  logic [INDEX_BITS-1:0] r_miss_idx;

  logic [TAG_BITS-1:0]   w_tag;
  logic [INDEX_BITS-1:0] w_idx;
  logic [1:0]            w_off;
  logic                  w_req;
  logic                  w_hit;
  logic                  w_wr_hit;
  logic                  w_hit_acc;
  logic                  w_miss;

  assign w_tag = ADDRESS[7 -: TAG_BITS];
  assign w_idx = ADDRESS[2 +: INDEX_BITS];
  assign w_off = ADDRESS[1:0];
  assign w_req = READ | WRITE;
  assign w_hit = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign o_dbg_state = r_state;

  always_comb begin
    w_next        = r_state;
    BUSYWAIT      = 1'b0;
    READDATA      = 8'h00;
    MEM_READ      = 1'b0;
    MEM_WRITE     = 1'b0;
    MEM_ADDRESS   = {r_miss_tag, r_miss_idx};
    MEM_WRITEDATA = r_data[r_miss_idx];
    w_wr_hit      = 1'b0;
    w_hit_acc     = 1'b0;
    w_miss        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          if (w_hit) begin
            w_hit_acc = 1'b1;
            // Simultaneous READ and WRITE behaves as a store.
            if (WRITE) w_wr_hit = 1'b1;
            else       READDATA = r_data[w_idx][{w_off, 3'b000} +: 8];
          end else begin
            BUSYWAIT = 1'b1;
            w_miss   = 1'b1;
            w_next   = (r_valid[w_idx] && r_dirty[w_idx]) ? S_WRITEBACK : S_FETCH;
          end
        end
      end
      S_WRITEBACK: begin
        BUSYWAIT    = 1'b1;
        MEM_WRITE   = 1'b1;
        MEM_ADDRESS = {r_tag[r_miss_idx], r_miss_idx};
        if (!MEM_BUSYWAIT) w_next = S_FETCH;
      end
      S_FETCH: begin
        BUSYWAIT = 1'b1;
        MEM_READ = 1'b1;
        if (!MEM_BUSYWAIT) w_next = S_UPDATE;
      end
      S_UPDATE: begin
        BUSYWAIT = 1'b1;
        w_next   = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    // CPU-facing outputs must drop the moment reset asserts, before any edge.
    if (!RESET_N) begin
      BUSYWAIT  = 1'b0;
      READDATA  = 8'h00;
      w_wr_hit  = 1'b0;
      w_hit_acc = 1'b0;
      w_miss    = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state    <= S_IDLE;
      r_valid    <= '0;
      r_dirty    <= '0;
      r_miss_tag <= '0;
      r_miss_idx <= '0;
    end else begin
      r_state <= w_next;
      // The miss block is latched so the fill completes even if the CPU lets go.
      if (w_miss) begin
        r_miss_tag <= w_tag;
        r_miss_idx <= w_idx;
      end
      if (w_wr_hit) r_dirty[w_idx] <= 1'b1;
      if (r_state == S_UPDATE) begin
        r_valid[r_miss_idx] <= 1'b1;
        r_dirty[r_miss_idx] <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (w_wr_hit) r_data[w_idx][{w_off, 3'b000} +: 8] <= WRITEDATA;
    if (r_state == S_UPDATE) begin
      r_data[r_miss_idx] <= MEM_READDATA;
      r_tag[r_miss_idx]  <= r_miss_tag;
    end
  end

`ifdef DCACHE_STATS_EN
  logic        r_after_update;
  logic [15:0] r_hit_count;
  logic [15:0] r_miss_count;

  // The hit that retires a miss right after UPDATE is not a fresh access.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_after_update <= 1'b0;
      r_hit_count    <= '0;
      r_miss_count   <= '0;
    end else begin
      r_after_update <= (r_state == S_UPDATE);
      if (w_hit_acc && !r_after_update && (r_hit_count != 16'hFFFF))
        r_hit_count <= r_hit_count + 16'd1;
      if (w_miss && (r_miss_count != 16'hFFFF))
        r_miss_count <= r_miss_count + 16'd1;
    end
  end

  assign HIT_COUNT  = r_hit_count;
  assign MISS_COUNT = r_miss_count;
`endif

endmodule

// File: tb/tb_data_cache.sv
// Bench for data_cache: byte-addressable memory model plus per-set cache bookkeeping,
// with a memory responder that checks every block transfer against an expected queue.
module tb_data_cache;

  logic        CLK;
  logic        RESET_N;
  logic        READ;
  logic        WRITE;
  logic [7:0]  ADDRESS;
  logic [7:0]  WRITEDATA;
  logic [7:0]  READDATA;
  logic        BUSYWAIT;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [5:0]  MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA;
  logic [31:0] MEM_READDATA;
  logic        MEM_BUSYWAIT;
  logic [1:0]  o_dbg_state;
`ifdef DCACHE_STATS_EN
  logic [15:0] HIT_COUNT;
  logic [15:0] MISS_COUNT;
`endif

  data_cache dut (
    .CLK(CLK), .RESET_N(RESET_N), .READ(READ), .WRITE(WRITE),
    .ADDRESS(ADDRESS), .WRITEDATA(WRITEDATA), .READDATA(READDATA),
    .BUSYWAIT(BUSYWAIT), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
    .MEM_ADDRESS(MEM_ADDRESS), .MEM_WRITEDATA(MEM_WRITEDATA),
    .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT),
    .o_dbg_state(o_dbg_state)
`ifdef DCACHE_STATS_EN
    , .HIT_COUNT(HIT_COUNT), .MISS_COUNT(MISS_COUNT)
`endif
  );

  // clock
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  // expected memory transfers: {is_write, block_addr[5:0], data[31:0]}
  logic [38:0] exp_q[$];

  logic [31:0] phys_mem  [64];
  logic [31:0] model_mem [64];
  logic [7:0]  ref_bytes [256];
  logic [7:0]  m_valid;
  logic [7:0]  m_dirty;
  logic [2:0]  m_tag [8];
  int          n_hit;
  int          n_miss;
  int          last_wb_lat;
  int          last_f_lat;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // memory responder and per-cycle transfer checker
  logic        resp_active = 1'b0;
  int          resp_cnt    = 0;
  int          resp_lat    = 0;
  logic [38:0] resp_cur;

  always @(negedge CLK) begin
    if (!RESET_N) begin
      resp_active  = 1'b0;
      MEM_BUSYWAIT = 1'b0;
    end else begin
      chk("mem_no_overlap", {31'd0, MEM_READ & MEM_WRITE}, 32'd0);
      if (MEM_READ || MEM_WRITE) begin
        resp_cur = {MEM_WRITE, MEM_ADDRESS, MEM_WRITE ? MEM_WRITEDATA : 32'h0};
        if (exp_q.size() == 0) begin
          chk("mem_unexpected_req", {25'd0, resp_cur[38:32]}, 32'hFFFF_FFFF);
        end else begin
          chk("mem_req_addr", {25'd0, resp_cur[38:32]}, {25'd0, exp_q[0][38:32]});
          chk("mem_req_wdata", resp_cur[31:0], exp_q[0][31:0]);
        end
        if (!resp_active) begin
          resp_active = 1'b1;
          resp_cnt    = 0;
          resp_lat    = $urandom_range(0, 3);
          if (MEM_WRITE) last_wb_lat = resp_lat;
          else           last_f_lat  = resp_lat;
        end else begin
          resp_cnt++;
        end
        if (MEM_READ) MEM_READDATA = phys_mem[MEM_ADDRESS];
        MEM_BUSYWAIT = (resp_cnt < resp_lat);
        if (!MEM_BUSYWAIT) begin
          if (MEM_WRITE) phys_mem[MEM_ADDRESS] = MEM_WRITEDATA;
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          resp_active = 1'b0;
        end
      end else begin
        resp_active  = 1'b0;
        MEM_BUSYWAIT = 1'b0;
      end
    end
  end

  // Cache is transparent: reads see the latest store; bookkeeping predicts transfers.
  task automatic model_step(input logic wr, input logic [7:0] addr, input logic [7:0] data,
                            output logic hit, output logic wb, output logic [7:0] exp_rd);
    logic [2:0]  idx;
    logic [2:0]  tg;
    logic [5:0]  victim;
    logic [31:0] blk;
    idx = addr[4:2];
    tg  = addr[7:5];
    hit = m_valid[idx] && (m_tag[idx] == tg);
    wb  = !hit && m_valid[idx] && m_dirty[idx];
    if (!hit) begin
      n_miss++;
      if (wb) begin
        victim = {m_tag[idx], idx};
        blk = {ref_bytes[{victim, 2'd3}], ref_bytes[{victim, 2'd2}],
               ref_bytes[{victim, 2'd1}], ref_bytes[{victim, 2'd0}]};
        exp_q.push_back({1'b1, victim, blk});
        model_mem[victim] = blk;
      end
      exp_q.push_back({1'b0, tg, idx, 32'h0});
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tg;
      m_dirty[idx] = 1'b0;
    end else begin
      n_hit++;
    end
    exp_rd = ref_bytes[addr];
    if (wr) begin
      m_dirty[idx]    = 1'b1;
      ref_bytes[addr] = data;
    end
  endtask

  task automatic model_reset();
    logic [31:0] w;
    m_valid = '0;
    m_dirty = '0;
    exp_q.delete();
    n_hit  = 0;
    n_miss = 0;
    for (int b = 0; b < 64; b++) begin
      w = model_mem[b];
      for (int k = 0; k < 4; k++) ref_bytes[b*4 + k] = w[k*8 +: 8];
    end
  endtask

  // driver: called at a falling edge, returns at the falling edge after completion
  task automatic do_access(input logic rd, input logic wr, input logic [7:0] addr,
                           input logic [7:0] data, output logic [7:0] rdata, output int stall);
    logic       hit;
    logic       wb;
    logic [7:0] exp_rd;
    int         exp_stall;
    model_step(wr, addr, data, hit, wb, exp_rd);
    READ = rd; WRITE = wr; ADDRESS = addr; WRITEDATA = data;
    #1;
    stall = 0;
    while (BUSYWAIT === 1'b1 && stall < 100) begin
      @(negedge CLK); #1;
      stall++;
    end
    exp_stall = hit ? 0 : 1 + (wb ? last_wb_lat + 1 : 0) + last_f_lat + 1 + 1;
    chk("stall_cycles", stall, exp_stall);
    rdata = READDATA;
    if (rd && !wr) chk("readdata", {24'd0, READDATA}, {24'd0, exp_rd});
    @(negedge CLK);
    READ = 1'b0; WRITE = 1'b0;
  endtask

  task automatic reset_mid_fetch(input logic [7:0] addr);
    logic       hit;
    logic       wb;
    logic [7:0] exp_rd;
    int         n;
    model_step(1'b0, addr, 8'h00, hit, wb, exp_rd);
    READ = 1'b1; ADDRESS = addr;
    n = 0;
    while (!MEM_READ && n < 20) begin
      @(negedge CLK);
      n++;
    end
    chk("rst_fetch_seen", {31'd0, MEM_READ}, 32'd1);
    #2;
    RESET_N = 1'b0;
    #1;
    chk("rst_mem_read", {31'd0, MEM_READ}, 32'd0);
    chk("rst_mem_write", {31'd0, MEM_WRITE}, 32'd0);
    chk("rst_busywait", {31'd0, BUSYWAIT}, 32'd0);
    chk("rst_readdata", {24'd0, READDATA}, 32'd0);
    READ = 1'b0;
    model_reset();
    @(negedge CLK); @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);
  endtask

  task automatic abandon(input logic [7:0] addr);
    logic       hit;
    logic       wb;
    logic [7:0] exp_rd;
    int         n;
    model_step(1'b0, addr, 8'h00, hit, wb, exp_rd);
    READ = 1'b1; ADDRESS = addr;
    @(negedge CLK);
    READ = 1'b0;
    #1;
    n = 0;
    while (BUSYWAIT === 1'b1 && n < 100) begin
      @(negedge CLK); #1;
      n++;
    end
    chk("abandon_fill_done", {31'd0, BUSYWAIT}, 32'd0);
    @(negedge CLK);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rd;
    int         st;
    int         op;
    int         tg;
    int         ix;
    int         of;
    logic [7:0] a;
    logic [7:0] d;

    for (int b = 0; b < 64; b++) phys_mem[b] = $urandom;
    phys_mem[6'h00] = 32'h44332211;
    phys_mem[6'h08] = 32'hDDCCBBAA;
    for (int b = 0; b < 64; b++) model_mem[b] = phys_mem[b];
    model_reset();
    last_wb_lat = 0; last_f_lat = 0;

    // reset block
    RESET_N = 1'b0; READ = 1'b0; WRITE = 1'b0; ADDRESS = 8'h00; WRITEDATA = 8'h00;
    MEM_BUSYWAIT = 1'b0; MEM_READDATA = 32'h0;
    #3;
    chk("reset_busywait", {31'd0, BUSYWAIT}, 32'd0);
    chk("reset_mem_read", {31'd0, MEM_READ}, 32'd0);
    chk("reset_mem_write", {31'd0, MEM_WRITE}, 32'd0);
    chk("reset_readdata", {24'd0, READDATA}, 32'd0);
    @(negedge CLK); @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);

    // directed scenario with literal expectations
    do_access(1'b1, 1'b0, 8'h00, 8'h00, rd, st);
    chk("tp_rd00", {24'd0, rd}, 32'h11);
    chk("tp_rd00_missed", {31'd0, st > 0}, 32'd1);
    do_access(1'b1, 1'b0, 8'h03, 8'h00, rd, st);
    chk("tp_rd03", {24'd0, rd}, 32'h44);
    chk("tp_rd03_nostall", st, 32'd0);
    do_access(1'b0, 1'b1, 8'h01, 8'hAB, rd, st);
    chk("tp_wr01_nostall", st, 32'd0);
    do_access(1'b1, 1'b0, 8'h01, 8'h00, rd, st);
    chk("tp_rd01", {24'd0, rd}, 32'hAB);
    do_access(1'b1, 1'b0, 8'h20, 8'h00, rd, st);
    chk("tp_wb_block", phys_mem[6'h00], 32'h4433AB11);
    chk("tp_rd20", {24'd0, rd}, 32'hAA);
    do_access(1'b0, 1'b1, 8'h44, 8'h5C, rd, st);
    do_access(1'b1, 1'b0, 8'h44, 8'h00, rd, st);
    chk("tp_rd44", {24'd0, rd}, 32'h5C);
    chk("tp_rd44_nostall", st, 32'd0);

    // reset mid-fetch, then previously cached blocks must miss again
    reset_mid_fetch(8'h08);
    do_access(1'b1, 1'b0, 8'h00, 8'h00, rd, st);
    chk("post_rst_rd00", {24'd0, rd}, 32'h11);
    chk("post_rst_rd00_missed", {31'd0, st > 0}, 32'd1);

    // CPU lets go mid-miss; the block still lands
    abandon(8'hFC);
    do_access(1'b1, 1'b0, 8'hFC, 8'h00, rd, st);
    chk("abandon_refill_hit", st, 32'd0);

    // randomized traffic over a few tags to mix hits, clean and dirty misses
    for (int i = 0; i < 400; i++) begin
      op = $urandom_range(0, 9);
      tg = $urandom_range(0, 2);
      ix = $urandom_range(0, 7);
      of = $urandom_range(0, 3);
      a  = {tg[2:0], ix[2:0], of[1:0]};
      d  = 8'($urandom);
      if (op < 5)      do_access(1'b1, 1'b0, a, d, rd, st);
      else if (op < 9) do_access(1'b0, 1'b1, a, d, rd, st);
      else             do_access(1'b1, 1'b1, a, d, rd, st);
    end

    chk("exp_q_drained", exp_q.size(), 32'd0);
`ifdef DCACHE_STATS_EN
    chk("hit_count", {16'd0, HIT_COUNT}, n_hit);
    chk("miss_count", {16'd0, MISS_COUNT}, n_miss);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
